// File: rtl/nios_ii_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : nios_ii_i2c_target
// Brief    : I2C target (slave) with a 7-bit address and an Avalon-MM
//            register interface for a Nios II host.
// Revision : 1.0 - initial release
// ============================================================================
module nios_ii_i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ADDR      = 3'd1;
    localparam logic [2:0] c_ADDR_ACK  = 3'd2;
    localparam logic [2:0] c_RX        = 3'd3;
    localparam logic [2:0] c_RX_ACK    = 3'd4;
    localparam logic [2:0] c_TX        = 3'd5;
    localparam logic [2:0] c_TX_ACK    = 3'd6;
    localparam logic [2:0] c_WAIT_STOP = 3'd7;

    logic       r_scl_meta, r_scl_sync, r_scl_prev;
    logic       r_sda_meta, r_sda_sync, r_sda_prev;
    logic [2:0] r_state, w_state_nxt;
    logic [3:0] r_bit_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_oe, w_oe_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_mack, w_mack_nxt;
    logic       w_rx_load, w_nack_set;
    logic [7:0] r_tx_data, r_rx_data;
    logic       r_rx_valid, r_overrun, r_last_nack;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic       w_wr, w_clr;
    logic       w_unused;

    // Synchronisers idle high so a reset never looks like a bus event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_in;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= sda_in;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
        end
    end

    assign w_scl_rise = r_scl_sync & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_sync & r_scl_prev;
    assign w_start    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
    assign w_stop     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_oe_nxt    = r_sda_oe;
        w_rw_nxt    = r_rw;
        w_mack_nxt  = r_mack;
        w_rx_load   = 1'b0;
        w_nack_set  = 1'b0;
        if (w_stop) begin
            w_state_nxt = c_IDLE;
            w_oe_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt = c_ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
        end else begin
            case (r_state)
                c_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], r_sda_sync};
                        w_cnt_nxt   = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_shift[7:1] == SLAVE_ADDR) begin
                            w_state_nxt = c_ADDR_ACK;
                            w_oe_nxt    = 1'b1;
                            w_rw_nxt    = r_shift[0];
                        end else begin
                            w_state_nxt = c_WAIT_STOP;
                            w_oe_nxt    = 1'b0;
                        end
                    end
                end
                c_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            // First TX bit goes out on the same edge that ends the ACK.
                            w_shift_nxt = r_tx_data;
                            w_oe_nxt    = ~r_tx_data[7];
                            w_cnt_nxt   = 4'd1;
                            w_state_nxt = c_TX;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = c_RX;
                        end
                    end
                end
                c_RX: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], r_sda_sync};
                        w_cnt_nxt   = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_rx_load   = 1'b1;
                        w_oe_nxt    = 1'b1;
                        w_state_nxt = c_RX_ACK;
                    end
                end
                c_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = c_RX;
                    end
                end
                c_TX: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = c_TX_ACK;
                        end else begin
                            w_oe_nxt    = ~r_shift[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_cnt_nxt   = r_bit_cnt + 4'd1;
                        end
                    end
                end
                c_TX_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = r_sda_sync;
                    end else if (w_scl_fall) begin
                        if (!r_mack) begin
                            w_shift_nxt = r_tx_data;
                            w_oe_nxt    = ~r_tx_data[7];
                            w_cnt_nxt   = 4'd1;
                            w_state_nxt = c_TX;
                        end else begin
                            w_nack_set  = 1'b1;
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = c_WAIT_STOP;
                        end
                    end
                end
                default: w_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_sda_oe  <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_sda_oe  <= w_oe_nxt;
            r_rw      <= w_rw_nxt;
            r_mack    <= w_mack_nxt;
        end
    end

    assign sda_oe = r_sda_oe;

    assign w_wr     = chipselect & ~write_n;
    assign w_clr    = w_wr && (address == 2'd2);
    assign w_unused = &{1'b0, writedata[31:8]};

    // Hardware set events take priority over software write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_data   <= 8'd0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_last_nack <= 1'b0;
        end else begin
            if (w_wr && address == 2'd0) r_tx_data <= writedata[7:0];
            if (w_rx_load) r_rx_data <= r_shift;

            if (w_rx_load)                  r_rx_valid <= 1'b1;
            else if (w_clr && writedata[0]) r_rx_valid <= 1'b0;

            if (w_rx_load && r_rx_valid)    r_overrun <= 1'b1;
            else if (w_clr && writedata[1]) r_overrun <= 1'b0;

            if (w_nack_set)                 r_last_nack <= 1'b1;
            else if (w_clr && writedata[3]) r_last_nack <= 1'b0;
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata = {24'd0, r_tx_data};
            2'd1:    readdata = {24'd0, r_rx_data};
            2'd2:    readdata = {28'd0, r_last_nack, (r_state != c_IDLE), r_overrun, r_rx_valid};
            default: readdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_nios_ii_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_ii_i2c_target
// Brief    : Scoreboard bench driving an I2C master and Avalon host against
//            nios_ii_i2c_target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_ii_i2c_target;

    localparam int c_Q = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic        scl_m, sda_m;
    logic        watch, oe_seen;

    typedef struct {
        string       name;
        logic [31:0] val;
    } item_t;

    item_t exp_q[$];
    item_t act_q[$];
    int    checks   = 0;
    int    failures = 0;

    nios_ii_i2c_target #(.SLAVE_ADDR(7'h50)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_oe     (sda_oe)
    );

    always #5 clk = ~clk;

    // Open-drain bus: the line is low if either side pulls it.
    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    always @(posedge clk) begin
        if (!watch)      oe_seen <= 1'b0;
        else if (sda_oe) oe_seen <= 1'b1;
    end

    task automatic expect_v(input string n, input logic [31:0] v);
        item_t it;
        it.name = n;
        it.val  = v;
        exp_q.push_back(it);
    endtask

    task automatic observe(input string n, input logic [31:0] v);
        item_t it;
        it.name = n;
        it.val  = v;
        act_q.push_back(it);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (act_q.size() > 0) begin
                item_t a;
                item_t e;
                a = act_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s: actual %h with no expected value queued", a.name, a.val);
                end else begin
                    e = exp_q.pop_front();
                    if (a.val !== e.val || a.name != e.name) begin
                        failures++;
                        $display("FAIL %s: actual %h required %h (%s)", a.name, a.val, e.val, e.name);
                    end
                end
            end
        end
    end

    task automatic qwait();
        repeat (c_Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
        qwait();
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        sda_m = b;    qwait();
        scl_m = 1'b1; qwait();
        s = sda_in;   qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic send(input string n, input logic [7:0] d, input logic exp_ack);
        logic s;
        logic ack;
        expect_v(n, {31'd0, exp_ack});
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], s);
        i2c_bit(1'b1, ack);
        observe(n, {31'd0, ack});
    endtask

    task automatic recv(input string n, input logic mack, input logic [7:0] exp_d);
        logic       s;
        logic [7:0] d;
        expect_v(n, {24'd0, exp_d});
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(mack, s);
        observe(n, {24'd0, d});
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic chk_reg(input string n, input logic [1:0] a, input logic [31:0] e);
        expect_v(n, e);
        @(negedge clk);
        address = a;
        #1 observe(n, readdata);
    endtask

    task automatic chk_oe(input string n, input logic e);
        expect_v(n, {31'd0, e});
        observe(n, {31'd0, sda_oe});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; scl_m = 1'b1; sda_m = 1'b1; watch = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        chk_reg("rst_tx_data", 2'd0, 32'h0);
        chk_reg("rst_rx_data", 2'd1, 32'h0);
        chk_reg("rst_status",  2'd2, 32'h0);
        chk_reg("rst_reg3",    2'd3, 32'h0);
        chk_oe("rst_sda_oe", 1'b0);

        // Write transaction with both bytes acknowledged.
        i2c_start();
        send("wr_addr_a0", 8'hA0, 1'b0);
        send("wr_data_3c", 8'h3C, 1'b0);
        i2c_stop();
        chk_reg("wr_rx_data", 2'd1, 32'h3C);
        chk_reg("wr_status",  2'd2, 32'h1);
        reg_wr(2'd2, 32'h1);
        chk_reg("wr_clear",   2'd2, 32'h0);

        // Read transaction: master ACKs one byte then NACKs.
        reg_wr(2'd0, 32'h96);
        chk_reg("tx_reg", 2'd0, 32'h96);
        i2c_start();
        send("rd_addr_a1", 8'hA1, 1'b0);
        recv("rd_byte0", 1'b0, 8'h96);
        recv("rd_byte1", 1'b1, 8'h96);
        i2c_stop();
        chk_reg("rd_status", 2'd2, 32'h8);
        reg_wr(2'd2, 32'h8);
        chk_reg("rd_clear",  2'd2, 32'h0);

        // Foreign address: no ACK and SDA never pulled.
        watch = 1'b1;
        i2c_start();
        send("nak_addr_b0", 8'hB0, 1'b1);
        i2c_stop();
        expect_v("nak_oe_seen", 32'h0);
        observe("nak_oe_seen", {31'd0, oe_seen});
        watch = 1'b0;
        chk_reg("nak_status", 2'd2, 32'h0);

        // Two bytes without servicing rx_data -> overrun.
        i2c_start();
        send("ov_addr_a0", 8'hA0, 1'b0);
        send("ov_data_11", 8'h11, 1'b0);
        send("ov_data_22", 8'h22, 1'b0);
        i2c_stop();
        chk_reg("ov_rx_data", 2'd1, 32'h22);
        chk_reg("ov_status",  2'd2, 32'h3);
        reg_wr(2'd2, 32'h3);
        chk_reg("ov_clear",   2'd2, 32'h0);

        // Write then repeated START into a read.
        reg_wr(2'd0, 32'h5A);
        i2c_start();
        send("rs_addr_a0", 8'hA0, 1'b0);
        send("rs_data_55", 8'h55, 1'b0);
        i2c_start();
        send("rs_addr_a1", 8'hA1, 1'b0);
        recv("rs_byte", 1'b1, 8'h5A);
        i2c_stop();
        chk_reg("rs_rx_data", 2'd1, 32'h55);
        chk_reg("rs_status",  2'd2, 32'h9);
        reg_wr(2'd2, 32'h9);

        // Reset while the target holds SDA low for a TX zero bit.
        reg_wr(2'd0, 32'h0);
        i2c_start();
        send("mr_addr_a1", 8'hA1, 1'b0);
        chk_oe("mr_oe_before", 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_oe("mr_oe_async", 1'b0);
        chk_reg("mr_status_in_reset", 2'd2, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_reg("mr_status_after", 2'd2, 32'h0);
        chk_oe("mr_oe_after", 1'b0);
        i2c_stop();
        chk_reg("mr_status_idle", 2'd2, 32'h0);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0 || act_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: actual %0d/%0d pending items required 0/0", exp_q.size(), act_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_ii_i2c_target.md
NIOS_II_I2C_TARGET -- requirements
Module: nios_ii_i2c_target

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit I2C address this target answers.
REQ-002 SHALL have port clk  input  1  system clock; the only clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port address  input  2  Avalon-MM slave word address.
REQ-005 SHALL have port chipselect  input  1  Avalon slave select.
REQ-006 SHALL have port write_n  input  1  active-low Avalon write strobe.
REQ-007 SHALL have port writedata  input  32  Avalon write data.
REQ-008 SHALL have port readdata  output  32  Avalon read data; combinational; zero-extended.
REQ-009 SHALL have port scl_in  input  1  I2C SCL pin level; asynchronous to clk.
REQ-010 SHALL have port sda_in  input  1  I2C SDA pin level; asynchronous to clk.
REQ-011 SHALL have port sda_oe  output  1  1 = pull SDA low; 0 = release SDA (open-drain).

Function
REQ-012 SHALL pass scl_in and sda_in through 2-flop synchronisers, then a third registered stage for edge detection; all I2C logic uses the synchronised signals only.
REQ-013 SHALL detect START as an SDA falling edge while SCL is high, and STOP as an SDA rising edge while SCL is high.
REQ-014 SHALL sample SDA data bits on SCL rising edges and change sda_oe only on SCL falling edges, one clk after the falling edge is detected.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK and WAIT_STOP.
REQ-016 SHALL go from any state to ADDR on START (including repeated START), clearing the bit counter.
REQ-017 SHALL go from any state to IDLE on STOP and set sda_oe=0 in the same cycle.
REQ-018 In ADDR: after 8 bits, if bits[7:1]==SLAVE_ADDR, SHALL go to ADDR_ACK and drive sda_oe=1 for that ACK clock; otherwise SHALL go to WAIT_STOP with sda_oe=0.
REQ-019 At the falling edge ending ADDR_ACK, SHALL go to RX if R/W=0; if R/W=1, SHALL load the shift register from tx_data and go to TX.
REQ-020 In RX: after the 8th bit, SHALL copy the byte to rx_data, set rx_valid and go to RX_ACK with sda_oe=1; if rx_valid was already 1, SHALL also set overrun and overwrite rx_data.
REQ-021 At the falling edge ending RX_ACK, SHALL release SDA and return to RX.
REQ-022 In TX: SHALL drive sda_oe = ~bit, MSB first, for 8 bits, then release SDA and go to TX_ACK.
REQ-023 In TX_ACK: master ACK (SDA=0) SHALL reload tx_data and return to TX; NACK (SDA=1) SHALL set last_nack and go to WAIT_STOP.
REQ-024 WAIT_STOP SHALL keep sda_oe=0 and leave only on START or STOP.
REQ-025 Register 0 tx_data[7:0] SHALL be read/write; a write during TX affects the next byte load only.
REQ-026 Register 1 rx_data[7:0] SHALL be read-only.
REQ-027 Register 2 status SHALL hold bit0 rx_valid, bit1 overrun, bit2 busy (state != IDLE) and bit3 last_nack; writing 1 to bit 0, 1 or 3 clears that bit.
REQ-028 Register 3 SHALL read as 0.
REQ-029 A write SHALL take effect when chipselect=1 and write_n=0.
REQ-030 When a status clear and a set of the same bit occur in the same cycle, the set SHALL win.

Reset
REQ-031 On reset SHALL set state=IDLE, sda_oe=0, tx_data=0, rx_data=0 and all status bits to 0, and set the synchroniser flops to 1 (bus idle).
REQ-032 A reset asserted mid-transfer SHALL release SDA immediately (asynchronously) and ignore the bus until the next START.

Verification
REQ-033 Bench SHALL run: START, 0xA0, 0x3C, STOP -> target ACKs both bytes; rx_data=0x3C; status=0x1 after STOP.
REQ-034 Bench SHALL run: tx_data=0x96, then START, 0xA1, master ACK, master NACK, STOP -> target drives 0x96 twice; last_nack=1; busy=0.
REQ-035 Bench SHALL run: START, 0xB0, STOP -> no ACK; sda_oe=0 throughout; rx_valid=0.
REQ-036 Bench SHALL run two written bytes 0x11 then 0x22 with no read of status between them -> rx_data=0x22; status=0x3; writing 0x3 to register 2 gives status=0x0.
REQ-037 Bench SHALL run: START, 0xA0, 0x55, then repeated START, 0xA1 -> target re-ACKs the address and begins TX of tx_data.
REQ-038 Bench SHALL assert reset while the target drives a TX bit low -> sda_oe=0 at once; state=IDLE.
